// File: rtl/control_edicion.sv
// rtl/control_edicion.sv - Keypad-driven time editor feeding an RTC write handshake
// Optional 12-hour mode is compiled in with FORMATO_12H_EN.
module control_edicion (
    input  logic       clk,
    input  logic       reset,
    input  logic       Aumenta,
    input  logic       Disminuye,
    input  logic       Siguiente,
    input  logic       Anterior,
    input  logic       CambiarHora,
    input  logic       Formato,
    input  logic [4:0] hora_rtc,
    input  logic [5:0] min_rtc,
    input  logic [5:0] seg_rtc,
    input  logic       wr_ack,
    output logic [4:0] edit_hora,
    output logic [5:0] edit_min,
    output logic [5:0] edit_seg,
    output logic [1:0] campo,
    output logic       editando,
    output logic       escribir,
    output logic       formato12,
    output logic       pm
);

    typedef enum logic [2:0] {
        REPOSO,
        EDIT_HORA,
        EDIT_MIN,
        EDIT_SEG,
        ESCRIBE
    } estado_t;

    estado_t estado, estadoSig;

    logic [5:0] teclas, teclaReg, teclaPrev, flanco;
    logic       armado;
    logic       flFmt, flCam, flSig, flAnt, flAum, flDis;
    logic       subir, bajar;
    logic [4:0] horaCarga;

    assign teclas = {Formato, CambiarHora, Siguiente, Anterior, Aumenta, Disminuye};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            teclaReg  <= '0;
            teclaPrev <= '0;
            armado    <= 1'b0;
        end else begin
            teclaReg  <= teclas;
            // First sample after reset counts as already held, so a key kept
            // down across reset release never looks like a fresh press.
            teclaPrev <= armado ? teclaReg : teclas;
            armado    <= 1'b1;
        end
    end

    assign flanco = teclaReg & ~teclaPrev;
    assign flFmt  = flanco[5];
    assign flCam  = flanco[4];
    assign flSig  = flanco[3];
    assign flAnt  = flanco[2];
    assign flAum  = flanco[1];
    assign flDis  = flanco[0];

    assign subir = flAum & ~(flCam | flSig | flAnt);
    assign bajar = flDis & ~(flCam | flSig | flAnt | flAum);

    function automatic logic [4:0] subirHora(input logic [4:0] h, input logic modo12);
        if (modo12)
            return (h >= 5'd12 || h == 5'd0) ? 5'd1 : h + 5'd1;
        return (h >= 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [4:0] bajarHora(input logic [4:0] h, input logic modo12);
        if (modo12)
            return (h <= 5'd1 || h > 5'd12) ? 5'd12 : h - 5'd1;
        return (h == 5'd0 || h > 5'd23) ? 5'd23 : h - 5'd1;
    endfunction

    function automatic logic [5:0] subir60(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] bajar60(input logic [5:0] v);
        return (v == 6'd0 || v > 6'd59) ? 6'd59 : v - 6'd1;
    endfunction

`ifdef FORMATO_12H_EN
    logic pmCarga;

    always_comb begin
        horaCarga = hora_rtc;
        pmCarga   = 1'b0;
        if (formato12) begin
            pmCarga = (hora_rtc >= 5'd12);
            if (hora_rtc == 5'd0)
                horaCarga = 5'd12;
            else if (hora_rtc > 5'd12)
                horaCarga = hora_rtc - 5'd12;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            formato12 <= 1'b0;
            pm        <= 1'b0;
        end else if (estado == REPOSO) begin
            if (flCam)
                pm <= pmCarga;
            else if (flFmt)
                formato12 <= ~formato12;
        end else if (estado == EDIT_HORA && formato12) begin
            // The AM/PM boundary sits between 11 and 12 on a 12-hour dial.
            if ((subir && edit_hora == 5'd11) || (bajar && edit_hora == 5'd12))
                pm <= ~pm;
        end
    end
`else
    logic unusedFormato;

    assign horaCarga     = hora_rtc;
    assign formato12     = 1'b0;
    assign pm            = 1'b0;
    assign unusedFormato = flFmt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edit_hora <= '0;
            edit_min  <= '0;
            edit_seg  <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (flCam) begin
                        edit_hora <= horaCarga;
                        edit_min  <= min_rtc;
                        edit_seg  <= seg_rtc;
                    end
                end
                EDIT_HORA: begin
                    if (subir)
                        edit_hora <= subirHora(edit_hora, formato12);
                    else if (bajar)
                        edit_hora <= bajarHora(edit_hora, formato12);
                end
                EDIT_MIN: begin
                    if (subir)
                        edit_min <= subir60(edit_min);
                    else if (bajar)
                        edit_min <= bajar60(edit_min);
                end
                EDIT_SEG: begin
                    if (subir)
                        edit_seg <= subir60(edit_seg);
                    else if (bajar)
                        edit_seg <= bajar60(edit_seg);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            estado <= REPOSO;
        else
            estado <= estadoSig;
    end

    always_comb begin
        estadoSig = estado;
        case (estado)
            REPOSO: begin
                if (flCam)
                    estadoSig = EDIT_HORA;
            end
            EDIT_HORA: begin
                if (flCam)
                    estadoSig = ESCRIBE;
                else if (flSig)
                    estadoSig = EDIT_MIN;
                else if (flAnt)
                    estadoSig = EDIT_SEG;
            end
            EDIT_MIN: begin
                if (flCam)
                    estadoSig = ESCRIBE;
                else if (flSig)
                    estadoSig = EDIT_SEG;
                else if (flAnt)
                    estadoSig = EDIT_HORA;
            end
            EDIT_SEG: begin
                if (flCam)
                    estadoSig = ESCRIBE;
                else if (flSig)
                    estadoSig = EDIT_HORA;
                else if (flAnt)
                    estadoSig = EDIT_MIN;
            end
            ESCRIBE: begin
                if (wr_ack)
                    estadoSig = REPOSO;
            end
            default: estadoSig = REPOSO;
        endcase
    end

    always_comb begin
        campo    = 2'b00;
        escribir = 1'b0;
        case (estado)
            EDIT_HORA: campo = 2'b01;
            EDIT_MIN:  campo = 2'b10;
            EDIT_SEG:  campo = 2'b11;
            ESCRIBE:   escribir = 1'b1;
            default: ;
        endcase
    end

    assign editando = (campo != 2'b00);

endmodule
